ram_dp_be: RTL and testbench
============================

// Module: ram_dp_be
// PURPOSE
//  Parametrised simple dual-port synchronous RAM: one write port, one read port, one clock.
//  Next generation of the team's single-port RAM. Adds per-byte write enables, a selectable
//  read latency with a rd_valid strobe, and defined read-during-write behaviour.
//  Adds an optional post-reset memory clear sequencer. Used as the storage core for FIFOs
//  and packet buffers.
// PARAMETERS
//  RAM_WIDTH      32    data width in bits; must be a multiple of 8 (NUM_BYTES = RAM_WIDTH/8)
//  RAM_DEPTH      1024  number of words; need not be a power of two
//  ADDR_SIZE      10    address width; must satisfy 2**ADDR_SIZE >= RAM_DEPTH
//  READ_LATENCY   1     1 or 2 cycles from rd_en sample to data_out/rd_valid
//  RDW_MODE       0     same-address collision: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data)
//  CLEAR_ON_RESET 1     1 = write CLEAR_VALUE to every word after reset release
//  CLEAR_VALUE    0     RAM_WIDTH-bit fill value used by the clear sequence
// PORTS
//  clk        in   1          clock; all logic is rising-edge triggered
//  rst        in   1          asynchronous reset, active-low
//  wr_en      in   1          write request
//  wr_be      in   NUM_BYTES  byte enables; bit b covers data_in[8b+7:8b]
//  wr_add     in   ADDR_SIZE  write address
//  data_in    in   RAM_WIDTH  write data
//  rd_en      in   1          read request
//  rd_add     in   ADDR_SIZE  read address
//  data_out   out  RAM_WIDTH  read data
//  rd_valid   out  1          one-cycle strobe: data_out is valid this cycle
//  init_busy  out  1          high while the clear sequence runs; all requests are ignored
// BEHAVIOUR
//  Reset (rst=0):
//   - data_out=0, rd_valid=0, all latency-pipe valid bits=0, clear counter=0.
//   - init_busy=1 if CLEAR_ON_RESET, else 0.
//   - Memory contents are not touched by the asynchronous reset.
//  Control FSM states: CLEAR, READY.
//   - Reset release -> CLEAR if CLEAR_ON_RESET, else READY.
//   - CLEAR writes CLEAR_VALUE to address cnt each cycle, cnt = 0..RAM_DEPTH-1.
//   - After writing RAM_DEPTH-1 the FSM goes to READY. init_busy falls on that same edge,
//     so init_busy is high for exactly RAM_DEPTH cycles.
//   - Reset asserted mid-clear aborts the sweep; the sweep restarts at address 0 on release.
//  Write (READY, wr_en=1): on the rising edge, each lane b with wr_be[b]=1 takes data_in lane b.
//   - Unselected lanes keep their contents.
//   - wr_be=0 is a no-op.
//   - wr_add >= RAM_DEPTH is dropped silently.
//  Read (READY, rd_en=1, sampled at edge N):
//   - data_out updates and rd_valid=1 at edge N+READ_LATENCY-1 (latency 1 = registered RAM output).
//   - With READ_LATENCY=2 one extra output register is added; back-to-back reads are fully pipelined.
//   - rd_valid is high for exactly one cycle per accepted read.
//   - data_out holds its last value when no read completes.
//   - rd_add >= RAM_DEPTH returns 0, with rd_valid still asserted.
//  Collision (wr_en & rd_en & wr_add==rd_add, same edge):
//   - READ_FIRST returns pre-write contents.
//   - WRITE_FIRST returns the byte-merged result: enabled lanes from data_in, others old data.
//  Requests during CLEAR:
//   - wr_en and rd_en are ignored: no memory change, no rd_valid.
//   - There is no backpressure; the requester must wait for init_busy=0.
//  rd_en during reset: discarded; the pipe is flushed.
// STRUCTURE
//  ram_pkg:
//   - localparams RDW_READ_FIRST=0, RDW_WRITE_FIRST=1.
//   - typedef of FSM states {CLEAR, READY}.
//   - function be_merge(old, new, be) implementing the byte-lane merge.
//  Sub-module ram_init_ctrl: clear FSM, address counter, init_busy. It drives a write-port mux
//  that selects between the clear path and the user path.
//  Top level: memory array, byte-lane write, collision bypass, latency pipe.
// TESTING
//  1. Reset with CLEAR_ON_RESET=1, RAM_DEPTH=16:
//     - init_busy high for exactly 16 cycles after release.
//     - Then read all 16 addresses -> every word = CLEAR_VALUE.
//  2. Write 32'hDEADBEEF to addr 3 with wr_be=4'hF, then write 32'h11223344 to addr 3 with wr_be=4'b0101
//     -> read addr 3 returns 32'hDE22BE44.
//  3. READ_LATENCY=2, reads of addr 0,1,2 on three consecutive edges
//     -> rd_valid high for 3 consecutive cycles, data arrives 2 cycles after each request, in order.
//  4. Addr 5 holds 8'hAA in lane 0. Same-edge write 8'h55 (wr_be=4'b0001) and read of addr 5:
//     - RDW_MODE=0 -> lane 0 = 8'hAA.
//     - RDW_MODE=1 -> lane 0 = 8'h55.
//     - A subsequent read returns 8'h55 in both modes.
//  5. Assert rst at clear count 7, release:
//     - sweep restarts at 0.
//     - A write to addr 2 issued while init_busy=1 is lost: addr 2 reads CLEAR_VALUE.
//  6. RAM_DEPTH=10: write to addr 12 -> no effect; read addr 12 -> data_out=0 with rd_valid=1.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM family.
// Includes the FSM state type, the read-during-write mode codes and the byte-lane merge.
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // be_merge works on a fixed maximum width; callers zero-extend and truncate.
  localparam int BE_MAX_W = 1024;
  localparam int BE_MAX_B = BE_MAX_W / 8;

  typedef enum logic {CLEAR, READY} ram_state_e;

  function automatic logic [BE_MAX_W-1:0] be_merge(
    input logic [BE_MAX_W-1:0] old_word,
    input logic [BE_MAX_W-1:0] new_word,
    input logic [BE_MAX_B-1:0] be
  );
    logic [BE_MAX_W-1:0] m;
    for (int b = 0; b < BE_MAX_B; b++) begin
      m[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Post-reset clear sequencer for ram_dp_be.
// It also owns the write-port mux that chooses between the clear sweep and user writes.
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int                  RAM_WIDTH      = 32,
  parameter int                  RAM_DEPTH      = 1024,
  parameter int                  ADDR_SIZE      = 10,
  parameter int                  CLEAR_ON_RESET = 1,
  parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [RAM_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_SIZE-1:0]   wr_add,
  input  logic [RAM_WIDTH-1:0]   data_in,
  input  logic                   rd_en,
  output logic                   init_busy,
  output logic                   user_wr,
  output logic                   user_rd,
  output logic                   mem_we,
  output logic [RAM_WIDTH/8-1:0] mem_be,
  output logic [ADDR_SIZE-1:0]   mem_add,
  output logic [RAM_WIDTH-1:0]   mem_din
);

  localparam logic [ADDR_SIZE:0]   DEPTH_X = (ADDR_SIZE+1)'(RAM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(RAM_DEPTH - 1);

  ram_state_e           state;
  logic [ADDR_SIZE-1:0] cnt;
  logic                 wr_in_range;
  logic                 clr_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt       <= '0;
      init_busy <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            state     <= READY;
            init_busy <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          state <= READY;
        end
      endcase
    end
  end

  // The sweep must not write while reset is held, so memory stays untouched by reset.
  assign clr_we      = init_busy & rst;
  assign wr_in_range = ({1'b0, wr_add} < DEPTH_X);
  assign user_wr     = wr_en & ~init_busy & wr_in_range;
  assign user_rd     = rd_en & ~init_busy;

  assign mem_we  = clr_we | user_wr;
  assign mem_be  = clr_we ? '1          : wr_be;
  assign mem_add = clr_we ? cnt         : wr_add;
  assign mem_din = clr_we ? CLEAR_VALUE : data_in;

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with per-byte write enables, 1- or 2-cycle read latency with rd_valid,
// selectable read-during-write behaviour and an optional post-reset clear sweep.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int                   RAM_WIDTH      = 32,
  parameter int                   RAM_DEPTH      = 1024,
  parameter int                   ADDR_SIZE      = 10,
  parameter int                   READ_LATENCY   = 1,
  parameter int                   RDW_MODE       = 0,
  parameter int                   CLEAR_ON_RESET = 1,
  parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [RAM_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_SIZE-1:0]   wr_add,
  input  logic [RAM_WIDTH-1:0]   data_in,
  input  logic                   rd_en,
  input  logic [ADDR_SIZE-1:0]   rd_add,
  output logic [RAM_WIDTH-1:0]   data_out,
  output logic                   rd_valid,
  output logic                   init_busy
);

  localparam int                 NUM_BYTES = RAM_WIDTH / 8;
  localparam logic [ADDR_SIZE:0] DEPTH_X   = (ADDR_SIZE+1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic                 user_wr;
  logic                 user_rd;
  logic                 mem_we;
  logic [NUM_BYTES-1:0] mem_be;
  logic [ADDR_SIZE-1:0] mem_add;
  logic [RAM_WIDTH-1:0] mem_din;
  logic                 rd_in_range;
  logic [RAM_WIDTH-1:0] rd_word;

  ram_init_ctrl #(
    .RAM_WIDTH      (RAM_WIDTH),
    .RAM_DEPTH      (RAM_DEPTH),
    .ADDR_SIZE      (ADDR_SIZE),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .CLEAR_VALUE    (CLEAR_VALUE)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_be     (wr_be),
    .wr_add    (wr_add),
    .data_in   (data_in),
    .rd_en     (rd_en),
    .init_busy (init_busy),
    .user_wr   (user_wr),
    .user_rd   (user_rd),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_add   (mem_add),
    .mem_din   (mem_din)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (mem_be[b]) mem[mem_add][8*b +: 8] <= mem_din[8*b +: 8];
      end
    end
  end

  assign rd_in_range = ({1'b0, rd_add} < DEPTH_X);

  // Out-of-range reads return zero; WRITE_FIRST forwards the merged word on a same-address hit.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem[rd_add];
    if (RDW_MODE == RDW_WRITE_FIRST && user_wr && wr_add == rd_add) begin
      rd_word = RAM_WIDTH'(be_merge(BE_MAX_W'(rd_word), BE_MAX_W'(data_in), BE_MAX_B'(wr_be)));
    end
  end

  // ---- stage p0: registered RAM output ----
  logic                 vld_p0;
  logic [RAM_WIDTH-1:0] dat_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      dat_p0 <= '0;
    end else begin
      vld_p0 <= user_rd;
      if (user_rd) dat_p0 <= rd_word;
    end
  end

  // ---- stage p1: optional extra output register ----
  if (READ_LATENCY == 2) begin : g_lat2
    logic                 vld_p1;
    logic [RAM_WIDTH-1:0] dat_p1;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_p1 <= 1'b0;
        dat_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) dat_p1 <= dat_p0;
      end
    end

    assign data_out = dat_p1;
    assign rd_valid = vld_p1;
  end else begin : g_lat1
    assign data_out = dat_p0;
    assign rd_valid = vld_p0;
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench for ram_dp_be: two instances share stimulus, A = depth 16 / latency 1 / READ_FIRST,
// B = depth 10 / latency 2 / WRITE_FIRST; each read pushes hand-computed data and arrival cycle.
module tb_ram_dp_be;

  localparam logic [31:0] CVA = 32'hA5A5_0F0F;
  localparam logic [31:0] CVB = 32'h0000_5A5A;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_be = '0;
  logic [3:0]  wr_add = '0;
  logic [31:0] data_in = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_add = '0;

  logic [31:0] a_dout, b_dout;
  logic        a_vld, b_vld, a_busy, b_busy;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   na, nb;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_dp_be #(
    .RAM_WIDTH(32), .RAM_DEPTH(16), .ADDR_SIZE(4), .READ_LATENCY(1),
    .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CVA)
  ) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_add(wr_add),
    .data_in(data_in), .rd_en(rd_en), .rd_add(rd_add),
    .data_out(a_dout), .rd_valid(a_vld), .init_busy(a_busy)
  );

  ram_dp_be #(
    .RAM_WIDTH(32), .RAM_DEPTH(10), .ADDR_SIZE(4), .READ_LATENCY(2),
    .RDW_MODE(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CVB)
  ) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_add(wr_add),
    .data_in(data_in), .rd_en(rd_en), .rd_add(rd_add),
    .data_out(b_dout), .rd_valid(b_vld), .init_busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitors: pop one expectation per rd_valid and check both data and arrival cycle.
  always @(negedge clk) begin
    if (a_vld) begin
      if (qa.size() == 0) check("a_unexpected_valid", 32'(a_vld), 32'd0);
      else begin
        ea = qa.pop_front();
        check("a_data", a_dout, ea.d);
        check("a_latency", cyc, ea.c);
      end
    end
  end

  always @(negedge clk) begin
    if (b_vld) begin
      if (qb.size() == 0) check("b_unexpected_valid", 32'(b_vld), 32'd0);
      else begin
        eb = qb.pop_front();
        check("b_data", b_dout, eb.d);
        check("b_latency", cyc, eb.c);
      end
    end
  end

  task automatic op(input logic we, input logic [3:0] be, input logic [3:0] wa,
                    input logic [31:0] d, input logic re, input logic [3:0] ra,
                    input logic [31:0] exp_a, input logic [31:0] exp_b);
    @(posedge clk);
    #1;
    wr_en   = we;
    wr_be   = be;
    wr_add  = wa;
    data_in = d;
    rd_en   = re;
    rd_add  = ra;
    if (re) begin
      qa.push_back('{d: exp_a, c: cyc + 1});
      qb.push_back('{d: exp_b, c: cyc + 2});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Counts busy cycles after a reset release; optionally fires a write and a read mid-sweep.
  task automatic measure_busy(input bit inject, output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_busy) ca++;
      if (b_busy) cb++;
      if (inject && i == 5) begin
        wr_en = 1'b1; wr_be = 4'hF; wr_add = 4'd2; data_in = 32'hFFFF_FFFF;
        rd_en = 1'b1; rd_add = 4'd0;
      end else begin
        wr_en = 1'b0; wr_be = 4'h0; rd_en = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a_dout", a_dout, 32'h0);
    check("rst_b_dout", b_dout, 32'h0);
    check("rst_a_vld", 32'(a_vld), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd1);
    check("rst_b_busy", 32'(b_busy), 32'd1);

    @(posedge clk); #1 rst = 1'b1;
    measure_busy(1'b0, na, nb);
    check("a_busy_len", na, 32'd16);
    check("b_busy_len", nb, 32'd10);

    // Whole address space reads the clear value; B beyond depth 10 reads zero
    for (int a = 0; a < 16; a++) op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), CVA, (a < 10) ? CVB : 32'h0);

    // Byte-lane merge
    op(1'b1, 4'hF,    4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0, 32'h0);
    op(1'b1, 4'b0101, 4'd3, 32'h1122_3344, 1'b0, 4'd0, 32'h0, 32'h0);
    op(1'b0, 4'h0,    4'd0, 32'h0,         1'b1, 4'd3, 32'hDE22_BE44, 32'hDE22_BE44);

    // Back-to-back pipelined reads
    op(1'b1, 4'hF, 4'd1, 32'h0101_0101, 1'b0, 4'd0, 32'h0, 32'h0);
    op(1'b1, 4'hF, 4'd2, 32'h0202_0202, 1'b0, 4'd0, 32'h0, 32'h0);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0, CVA, CVB);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1, 32'h0101_0101, 32'h0101_0101);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h0202_0202, 32'h0202_0202);

    // Same-address collision: A returns old lane 0, B the merged word
    op(1'b1, 4'hF,    4'd5, 32'h1234_56AA, 1'b0, 4'd0, 32'h0, 32'h0);
    op(1'b1, 4'b0001, 4'd5, 32'h0000_0055, 1'b1, 4'd5, 32'h1234_56AA, 32'h1234_5655);
    op(1'b0, 4'h0,    4'd0, 32'h0,         1'b1, 4'd5, 32'h1234_5655, 32'h1234_5655);

    // wr_be = 0 is a no-op
    op(1'b1, 4'h0, 4'd7, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'h0, 32'h0);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7, CVA, CVB);

    // Address 12: in range for A, out of range for B
    op(1'b1, 4'hF, 4'd12, 32'hCAFE_F00D, 1'b0, 4'd0,  32'h0, 32'h0);
    op(1'b1, 4'hF, 4'd12, 32'h1111_1111, 1'b1, 4'd12, 32'hCAFE_F00D, 32'h0);
    op(1'b0, 4'h0, 4'd0,  32'h0,         1'b1, 4'd12, 32'h1111_1111, 32'h0);
    idle(4);
    check("a_drain1", qa.size(), 32'd0);
    check("b_drain1", qb.size(), 32'd0);

    // Reset with a read pending, then abort the sweep at count 7
    @(posedge clk); #1;
    rst = 1'b0; rd_en = 1'b1; rd_add = 4'd1;
    @(negedge clk);
    check("rst2_a_dout", a_dout, 32'h0);
    check("rst2_b_dout", b_dout, 32'h0);
    check("rst2_a_busy", 32'(a_busy), 32'd1);
    @(posedge clk); #1;
    rd_en = 1'b0; rst = 1'b1;
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_a_busy", 32'(a_busy), 32'd1);
    check("abort_b_busy", 32'(b_busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    measure_busy(1'b1, na, nb);
    check("a_busy_len2", na, 32'd16);
    check("b_busy_len2", nb, 32'd10);

    // Everything cleared again; the write issued while busy was lost
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2,  CVA, CVB);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3,  CVA, CVB);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd12, CVA, 32'h0);
    op(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5,  CVA, CVB);
    idle(4);
    check("a_drain2", qa.size(), 32'd0);
    check("b_drain2", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
